// File: rtl/adder_pkg.sv
// Shared types and default sizing for the adder and its downstream sum accumulator.
package adder_pkg;

  typedef enum logic {ACC_ACCUM, ACC_HOLD} acc_state_e;

  localparam int ADDER_WIDTH   = 4;
  localparam int ACC_WIDTH_DEF = 6;
  localparam int COUNT_N_DEF   = 4;

endpackage

// File: rtl/adder_sum_accumulator.sv
// Reduces the adder result stream in blocks of COUNT_N sums; each block total
// (modulo 2^ACC_WIDTH, plus a sticky overflow flag) is offered on a valid/ready port.
module adder_sum_accumulator
  import adder_pkg::*;
#(
  parameter int WIDTH     = ADDER_WIDTH,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int COUNT_N   = COUNT_N_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_overflow
);

  localparam int CW = $clog2(COUNT_N);
  localparam logic [CW-1:0] LAST_IDX = CW'(COUNT_N - 1);

  if (ACC_WIDTH < WIDTH) begin : g_bad_acc_width
    $error("ACC_WIDTH must be >= WIDTH");
  end
  if (COUNT_N < 2) begin : g_bad_count_n
    $error("COUNT_N must be >= 2");
  end

  // Handshakes: a beat moves on a rising edge where valid && ready. in_ready is
  // high only in ACCUM and out_valid only in HOLD, so the two never overlap.
  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 in_xfer;
  logic                 out_xfer;
  logic [ACC_WIDTH:0]   sum_ext;

  assign in_ready     = (state_q == ACC_ACCUM);
  assign out_valid    = (state_q == ACC_HOLD);
  assign out_acc      = acc_q;
  assign out_overflow = ovf_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign sum_ext  = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_sum};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (in_xfer) begin
      acc_d   = sum_ext[ACC_WIDTH-1:0];
      ovf_d   = ovf_q | sum_ext[ACC_WIDTH];
      count_d = count_q + 1'b1;
      if (count_q == LAST_IDX) begin
        state_d = ACC_HOLD;
      end
    end else if (out_xfer) begin
      state_d = ACC_ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // clear aborts exactly like rst, discarding any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ACC_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: default instance plus a COUNT_N=8 instance,
// each tracked by a running-total model and compared every cycle.
module tb_adder_sum_accumulator;
  import adder_pkg::*;

  localparam int W  = 4;
  localparam int AW = 6;
  localparam int N0 = 4;
  localparam int N1 = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear        [2];
  logic          in_valid     [2];
  logic          in_ready     [2];
  logic [W-1:0]  in_sum       [2];
  logic          out_valid    [2];
  logic          out_ready    [2];
  logic [AW-1:0] out_acc      [2];
  logic          out_overflow [2];

  always #5 clk = ~clk;

  adder_sum_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT_N(N0)) dut (
    .clk(clk), .rst(rst), .clear(clear[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sum(in_sum[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_acc(out_acc[0]), .out_overflow(out_overflow[0])
  );

  adder_sum_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT_N(N1)) dut8 (
    .clk(clk), .rst(rst), .clear(clear[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sum(in_sum[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_acc(out_acc[1]), .out_overflow(out_overflow[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: total of the samples accepted in the current block, as a plain integer.
  int tot     [2];
  int cnt     [2];
  int xfers   [2];
  int blocks0 = 0;
  bit hold    [2];
  logic [AW:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      tot[k] = 0; cnt[k] = 0; xfers[k] = 0; hold[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    bit fresh0;
    logic [AW:0] e;
    fresh0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (rst || clear[k]) begin
        tot[k] = 0; cnt[k] = 0; hold[k] = 1'b0;
      end else if (hold[k]) begin
        if (out_ready[k]) begin
          tot[k] = 0; cnt[k] = 0; hold[k] = 1'b0;
        end
      end else if (in_valid[k]) begin
        tot[k] += int'(in_sum[k]);
        cnt[k]++;
        xfers[k]++;
        if (cnt[k] == ((k == 0) ? N0 : N1)) begin
          hold[k] = 1'b1;
          if (k == 0) fresh0 = 1'b1;
        end
      end
    end
    if (fresh0) begin
      exp_q.push_back({tot[0] >= 64, AW'(tot[0] % 64)});
      blocks0++;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("in_ready[%0d]", k), in_ready[k], !hold[k]);
      check($sformatf("out_valid[%0d]", k), out_valid[k], hold[k]);
      check($sformatf("out_acc[%0d]", k), out_acc[k], tot[k] % 64);
      check($sformatf("out_overflow[%0d]", k), out_overflow[k], tot[k] >= 64);
    end
    if (fresh0) begin
      e = exp_q.pop_front();
      check("block_total", {out_overflow[0], out_acc[0]}, e);
    end
  end

  // Present one beat at a negedge and hold it across exactly one rising edge.
  task automatic step(input int k, input logic v, input logic [W-1:0] s);
    in_valid[k] = v;
    in_sum[k]   = s;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_sum[k]   = W'($urandom_range(0, 15));
  endtask

  initial begin
    int base_x, base_b, guard;
    logic [W-1:0] a, b;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      clear[k] = 1'b0; in_valid[k] = 1'b0; in_sum[k] = '0; out_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_out_acc", out_acc[0], 0);
    check("rst_out_overflow", out_overflow[0], 1'b0);
    check("rst_in_ready", in_ready[0], 1'b1);

    // Basic block 3+5+2+7 with the consumer always ready.
    out_ready[0] = 1'b1;
    step(0, 1'b1, 4'd3); step(0, 1'b1, 4'd5); step(0, 1'b1, 4'd2); step(0, 1'b1, 4'd7);
    check("basic_valid", out_valid[0], 1'b1);
    check("basic_acc", out_acc[0], 17);
    check("basic_ovf", out_overflow[0], 1'b0);
    @(negedge clk);
    check("basic_retired", out_valid[0], 1'b0);
    check("basic_in_ready", in_ready[0], 1'b1);

    // All-max samples: 60 fits in 6 bits; 8 of them wrap to 56 with overflow.
    for (int i = 0; i < N0; i++) step(0, 1'b1, 4'd15);
    check("max4_acc", out_acc[0], 60);
    check("max4_ovf", out_overflow[0], 1'b0);
    @(negedge clk);
    out_ready[0] = 1'b0;
    for (int i = 0; i < N1; i++) step(1, 1'b1, 4'd15);
    check("max8_valid", out_valid[1], 1'b1);
    check("max8_acc", out_acc[1], 56);
    check("max8_ovf", out_overflow[1], 1'b1);
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    check("max8_retired", out_valid[1], 1'b0);

    // Gapped input, then backpressure with in_valid pushing during HOLD.
    step(0, 1'b1, 4'd1); step(0, 1'b0, 4'd9); step(0, 1'b1, 4'd1);
    step(0, 1'b0, 4'd9); step(0, 1'b1, 4'd1); step(0, 1'b1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid[0], 1'b1);
      check("bp_acc", out_acc[0], 4);
      check("bp_in_ready", in_ready[0], 1'b0);
      in_valid[0] = 1'b1; in_sum[0] = 4'd9;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    check("bp_acc_end", out_acc[0], 4);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_retired", out_valid[0], 1'b0);
    check("bp_acc_zero", out_acc[0], 0);

    // Clear mid-block, then clear a pending HOLD block.
    step(0, 1'b1, 4'd9); step(0, 1'b1, 4'd9);
    clear[0] = 1'b1; @(negedge clk); clear[0] = 1'b0;
    check("clr_mid_acc", out_acc[0], 0);
    check("clr_mid_in_ready", in_ready[0], 1'b1);
    for (int i = 0; i < N0; i++) step(0, 1'b1, 4'd1);
    check("clr_next_acc", out_acc[0], 4);
    check("clr_next_valid", out_valid[0], 1'b1);
    clear[0] = 1'b1; @(negedge clk); clear[0] = 1'b0;
    check("clr_hold_valid", out_valid[0], 1'b0);
    check("clr_hold_acc", out_acc[0], 0);

    // Reset mid-block; the following block starts from zero.
    for (int i = 0; i < 3; i++) step(0, 1'b1, 4'd5);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("rst_mid_valid", out_valid[0], 1'b0);
    check("rst_mid_acc", out_acc[0], 0);
    check("rst_mid_ovf", out_overflow[0], 1'b0);
    check("rst_mid_in_ready", in_ready[0], 1'b1);
    out_ready[0] = 1'b1;
    for (int i = 0; i < N0; i++) step(0, 1'b1, 4'd2);
    check("rst_next_acc", out_acc[0], 8);
    @(negedge clk);

    // End-to-end: adder results (a+b, operands kept to 3 bits) for 40 transfers.
    base_x = xfers[0];
    base_b = blocks0;
    guard  = 0;
    while ((xfers[0] - base_x) < 40 && guard < 3000) begin
      a = W'($urandom_range(0, 7));
      b = W'($urandom_range(0, 7));
      in_valid[0]  = ($urandom_range(0, 3) != 0);
      in_sum[0]    = a + b;
      out_ready[0] = ($urandom_range(0, 2) != 0);
      in_valid[1]  = $urandom_range(0, 1) != 0;
      in_sum[1]    = W'($urandom_range(0, 15));
      out_ready[1] = $urandom_range(0, 1) != 0;
      clear[1]     = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      guard++;
    end
    in_valid[0] = 1'b0; in_valid[1] = 1'b0; clear[1] = 1'b0;
    check("e2e_budget", guard < 3000, 1'b1);
    check("e2e_blocks", blocks0 - base_b, 10);
    out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("e2e_drained", out_valid[0], 1'b0);
    check("e2e_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
- Downstream stage of the combinational adder: consumes its WIDTH-bit result stream through a valid/ready handshake.
- Accumulates COUNT_N consecutive sums into a wider ACC_WIDTH accumulator with a sticky overflow flag.
- Presents each completed block total on a valid/ready output port, so adder results can be checked and reduced in fixed-size groups.

Parameters:
- WIDTH, 4, width of the adder result fed into in_sum; must match the adder's WIDTH.
- ACC_WIDTH, 6, accumulator width; must be >= WIDTH (elaboration-time assertion).
- COUNT_N, 4, sums per block; must be >= 2 (elaboration-time assertion).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous block abort; priority below rst, above all other inputs.
- in_valid  input  1  in_sum holds a sum to accept.
- in_ready  output  1  block can accept a sum this cycle.
- in_sum  input  WIDTH  adder result, unsigned.
- out_valid  output  1  out_acc/out_overflow hold a completed block.
- out_ready  input  1  consumer takes the block this cycle.
- out_acc  output  ACC_WIDTH  block total, modulo 2^ACC_WIDTH.
- out_overflow  output  1  sticky: the block total exceeded 2^ACC_WIDTH-1.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-block: state=ACCUM, acc=0, count=0, ovf=0.
  - Reset outputs: out_valid=0, out_acc=0, out_overflow=0, in_ready=1 from the following cycle.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1, out_acc/out_overflow driven from registers and stable.
- Input handshake: a transfer occurs when in_valid && in_ready at an edge.
  - in_valid gaps are legal; count advances only on transfers.
  - in_sum is ignored when in_valid=0.
- Arithmetic on each transfer:
  - acc <= (acc + zero-extended in_sum) mod 2^ACC_WIDTH.
  - ovf <= ovf | carry-out of bit ACC_WIDTH-1.
  - count <= count+1. Counter width is $clog2(COUNT_N).
- Block completion: a transfer with count==COUNT_N-1 moves to HOLD.
  - out_valid rises the cycle after the last sample is accepted (latency 1).
  - out_acc includes that last sample.
- Output handshake: in HOLD, out_ready=1 at an edge retires the block.
  - Next state ACCUM; acc=0, count=0, ovf=0; in_ready=1 the next cycle.
  - No same-cycle bypass: a new sample cannot be accepted in the retire cycle, since in_ready=0 in HOLD.
- Backpressure: HOLD persists indefinitely while out_ready=0, and outputs must not change. out_ready in ACCUM is ignored.
- clear=1 at an edge, in any state: same effect as rst (ACCUM, acc/count/ovf=0).
  - Any in-flight transfer or retire in that cycle is discarded.
  - An unretired HOLD block is dropped: out_valid falls the next cycle.
- Simultaneous rst and clear: rst governs; the result is identical.
- out_acc and out_overflow are registered, not combinational. They show the running acc/ovf in ACCUM; the consumer qualifies them with out_valid.

Decomposition:
- Shared package adder_pkg holds:
  - typedef enum logic {ACC_ACCUM, ACC_HOLD} acc_state_e;
  - default constants ADDER_WIDTH=4, ACC_WIDTH_DEF=6, COUNT_N_DEF=4.
- No sub-module. Single always_ff for state/acc/count/ovf; combinational next-state and handshake outputs.

Test Plan:
- Basic block (defaults): rst 2 cycles, then 4 transfers of in_sum=3,5,2,7 with out_ready=1 → out_valid pulses 1 cycle after the 4th transfer, out_acc=17, out_overflow=0; in_ready=1 the following cycle.
- Max values, no overflow: 4×in_sum=15 → out_acc=60, out_overflow=0. Same stimulus with COUNT_N=8 → out_acc=56 (120 mod 64), out_overflow=1.
- Gapped input plus backpressure:
  - Stimulus: in_valid toggled 1,0,1,0,1,1 with sums 1,x,1,x,1,1; out_ready held 0 for 5 cycles after completion.
  - Required: out_acc=4; out_valid and out_acc stable across all 5 cycles; in_ready=0 throughout; block retires on the first out_ready=1 cycle.
- Clear mid-block and in HOLD:
  - Clear after 2 transfers of 9 → next block of 1,1,1,1 gives out_acc=4.
  - Clear while HOLD with out_ready=0 → out_valid=0 next cycle and no retire recorded.
- Reset mid-operation: rst after 3 transfers → out_valid=0, out_acc=0, out_overflow=0, in_ready=1; the next full block sums from zero.
- End-to-end with the adder: drive the adder with random a/b masked to avoid its overflow, feed result into in_sum for 40 transfers → 10 blocks; scoreboard checks each out_acc/out_overflow against a reference model.
